// File: rtl/sumador_multiciclo_if.sv
// Request/response bus of the slice-serial adder: operand request in, result out.
interface sumador_multiciclo_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data0_i;
   logic [WIDTH-1:0] data1_i;
   logic             carry_i;
   logic             sub_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] result_o;
   logic             carry_o;
   logic             overflow_o;
   logic             zero_o;

   modport master (
      output valid_i, data0_i, data1_i, carry_i, sub_i, ready_i,
      input  ready_o, valid_o, result_o, carry_o, overflow_o, zero_o
   );

   modport slave (
      input  valid_i, data0_i, data1_i, carry_i, sub_i, ready_i,
      output ready_o, valid_o, result_o, carry_o, overflow_o, zero_o
   );
endinterface

// File: rtl/sumador_multiciclo.sv
// Multi-cycle adder/subtractor: SLICE bits per clock, LSB slice first, N = WIDTH/SLICE cycles.
// Define SUMADOR_SATURACION_EN to clamp signed overflow instead of wrapping.
module sumador_multiciclo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   sumador_multiciclo_if.slave  bus
);
   localparam int unsigned N     = WIDTH / SLICE;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic [WIDTH-1:0]   acc_q,    acc_d;
   logic               carry_q,  carry_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic               valid_q,  valid_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q,   cout_d;
   logic               ovf_q,    ovf_d;
   logic               zero_q,   zero_d;

   logic               accept_c;
   logic               last_c;
   logic [SLICE:0]     slice_sum_c;
   logic [WIDTH-1:0]   acc_part_c;
   logic [WIDTH-1:0]   final_c;
   logic               ovf_c;

   assign bus.ready_o    = (state_q == IDLE) && rst_ni;
   assign bus.valid_o    = valid_q;
   assign bus.result_o   = result_q;
   assign bus.carry_o    = cout_q;
   assign bus.overflow_o = ovf_q;
   assign bus.zero_o     = zero_q;

   // Datapath for the slice selected by idx_q, plus the final flag/saturation logic.
   always_comb begin
      accept_c    = bus.ready_o && bus.valid_i;
      last_c      = (idx_q == IDX_W'(N - 1));
      slice_sum_c = {1'b0, a_q[idx_q*SLICE +: SLICE]} + {1'b0, b_q[idx_q*SLICE +: SLICE]}
                    + (SLICE+1)'(carry_q);
      acc_part_c  = acc_q;
      acc_part_c[idx_q*SLICE +: SLICE] = slice_sum_c[SLICE-1:0];
      ovf_c       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_part_c[WIDTH-1] != a_q[WIDTH-1]);
      final_c     = acc_part_c;
`ifdef SUMADOR_SATURACION_EN
      if (ovf_c) begin
         final_c = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               a_d     = bus.data0_i;
               b_d     = bus.sub_i ? ~bus.data1_i : bus.data1_i;
               carry_d = bus.sub_i ? 1'b1 : bus.carry_i;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_part_c;
            carry_d = slice_sum_c[SLICE];
            idx_d   = idx_q + IDX_W'(1);
            if (last_c) begin
               state_d  = DONE;
               valid_d  = 1'b1;
               result_d = final_c;
               cout_d   = slice_sum_c[SLICE];
               ovf_d    = ovf_c;
               zero_d   = (final_c == '0);
            end
         end
         DONE: begin
            if (bus.ready_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end
endmodule

// File: tb/tb_sumador_multiciclo.sv
// Self-checking bench for sumador_multiciclo: directed table, corner sequences, random vs. arithmetic model.
module tb_sumador_multiciclo;
   localparam int unsigned W = 32;
   localparam int unsigned S = 8;
   localparam int unsigned N = W / S;
`ifdef SUMADOR_SATURACION_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sumador_multiciclo_if #(.WIDTH(W)) bus  ();
   sumador_multiciclo_if #(.WIDTH(8)) bus8 ();

   sumador_multiciclo #(.WIDTH(W), .SLICE(S)) u_dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   sumador_multiciclo #(.WIDTH(8), .SLICE(8)) u_dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] r;
      logic        c;
      logic        o;
      logic        z;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic on the whole word.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic sub, output logic [31:0] r, output logic c,
                                 output logic o, output logic z);
      longint s;
      logic [32:0] u;
      if (!sub) begin
         u = {1'b0, a} + {1'b0, b} + 33'(cin);
         c = u[32];
         s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      end else begin
         u = {1'b0, a} - {1'b0, b};
         c = (a >= b);
         s = longint'($signed(a)) - longint'($signed(b));
      end
      r = u[31:0];
      o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      if (SAT && o) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      z = (r == 32'd0);
   endfunction

   task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
      chk({name, "_ready"}, 32'(bus.ready_o), 32'd1);
      bus.data0_i = a;
      bus.data1_i = b;
      bus.carry_i = cin;
      bus.sub_i   = sub;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      bus.data0_i = $urandom;
      bus.data1_i = $urandom;
      bus.carry_i = 1'($urandom);
      bus.sub_i   = 1'($urandom);
   endtask

   task automatic wait_valid(input string name);
      int lat = 0;
      while (bus.valid_o !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(N));
   endtask

   task automatic check_out(input string name, input logic [31:0] r, input logic c,
                            input logic o, input logic z);
      chk({name, "_result"},   bus.result_o,        r);
      chk({name, "_carry"},    32'(bus.carry_o),    32'(c));
      chk({name, "_overflow"}, 32'(bus.overflow_o), 32'(o));
      chk({name, "_zero"},     32'(bus.zero_o),     32'(z));
   endtask

   task automatic handshake(input string name);
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      chk({name, "_valid_drop"}, 32'(bus.valid_o), 32'd0);
      chk({name, "_ready_back"}, 32'(bus.ready_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] r;
      logic c, o, z, seen;
      bus.valid_i = 0; bus.ready_i = 0; bus.data0_i = 0; bus.data1_i = 0;
      bus.carry_i = 0; bus.sub_i = 0;
      bus8.valid_i = 0; bus8.ready_i = 0; bus8.data0_i = 0; bus8.data1_i = 0;
      bus8.carry_i = 0; bus8.sub_i = 0;

      vecs.push_back('{"carry_chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
                       SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{"sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"sub_neg_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
                       SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{"add_cin", 32'h1234_5678, 32'h0, 1'b1, 1'b0, 32'h1234_5679, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"sub_equal", 32'd7, 32'd7, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                       SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1});

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready",  32'(bus.ready_o), 32'd0);
      chk("rst_valid",  32'(bus.valid_o), 32'd0);
      check_out("rst", 32'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_release_ready", 32'(bus.ready_o), 32'd1);

      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         wait_valid(vecs[i].name);
         check_out(vecs[i].name, vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z);
         handshake(vecs[i].name);
      end

      // Backpressure: outputs hold and requests are ignored while DONE
      issue("bp", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      wait_valid("bp");
      for (int k = 0; k < 3; k++) begin
         bus.valid_i = 1'b1;
         bus.data0_i = $urandom;
         bus.data1_i = $urandom;
         @(posedge clk); #1;
         chk("bp_valid_hold", 32'(bus.valid_o), 32'd1);
         chk("bp_ready_low",  32'(bus.ready_o), 32'd0);
         check_out("bp_hold", 32'h3333_3333, 1'b0, 1'b0, 1'b0);
      end
      bus.valid_i = 1'b0;
      handshake("bp");
      repeat (6) @(posedge clk);
      #1;
      chk("bp_not_queued_ready", 32'(bus.ready_o), 32'd1);
      chk("bp_not_queued_valid", 32'(bus.valid_o), 32'd0);

      // Reset while RUN is on slice 2
      issue("rmid", 32'd100, 32'd200, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rmid_valid", 32'(bus.valid_o), 32'd0);
      chk("rmid_ready", 32'(bus.ready_o), 32'd0);
      check_out("rmid", 32'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rmid_ready_release", 32'(bus.ready_o), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.valid_o === 1'b1) seen = 1'b1;
      end
      chk("rmid_no_valid", 32'(seen), 32'd0);
      issue("fresh", 32'd3, 32'd4, 1'b0, 1'b0);
      wait_valid("fresh");
      check_out("fresh", 32'd7, 1'b0, 1'b0, 1'b0);
      handshake("fresh");

      // Randomized operations with random result backpressure
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a, b;
         logic cin, sub;
         a   = $urandom;
         b   = $urandom;
         cin = 1'($urandom);
         sub = 1'($urandom);
         if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
         if ($urandom_range(0, 3) == 0) b = a;
         model(a, b, cin, sub, r, c, o, z);
         issue("rnd", a, b, cin, sub);
         wait_valid("rnd");
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         check_out("rnd", r, c, o, z);
         handshake("rnd");
      end

      // Single-slice build: one-cycle latency
      chk("n1_ready", 32'(bus8.ready_o), 32'd1);
      bus8.data0_i = 8'h80;
      bus8.data1_i = 8'h80;
      bus8.valid_i = 1'b1;
      @(posedge clk); #1;
      bus8.valid_i = 1'b0;
      chk("n1_busy", 32'(bus8.ready_o), 32'd0);
      @(posedge clk); #1;
      chk("n1_valid",    32'(bus8.valid_o),    32'd1);
      chk("n1_result",   32'(bus8.result_o),   SAT ? 32'h80 : 32'h00);
      chk("n1_carry",    32'(bus8.carry_o),    32'd1);
      chk("n1_overflow", 32'(bus8.overflow_o), 32'd1);
      chk("n1_zero",     32'(bus8.zero_o),     SAT ? 32'd0 : 32'd1);
      bus8.ready_i = 1'b1;
      @(posedge clk); #1;
      bus8.ready_i = 1'b0;
      chk("n1_valid_drop", 32'(bus8.valid_o), 32'd0);
      chk("n1_ready_back", 32'(bus8.ready_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sumador_multiciclo.md
SUMADOR_MULTICICLO -- requirements
Module: sumador_multiciclo

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of SLICE and at least SLICE.
REQ-002 Parameter SLICE, default 8: bits added per clock; N = WIDTH/SLICE is the number of slices.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 valid_i  input  1  operand request valid.
REQ-006 ready_o  output  1  block can accept a request.
REQ-007 data0_i  input  WIDTH  operand A.
REQ-008 data1_i  input  WIDTH  operand B.
REQ-009 carry_i  input  1  carry-in; used for addition only.
REQ-010 sub_i  input  1  mode select: 0 = A+B+carry_i, 1 = A-B.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 result_o  output  WIDTH  sum or difference.
REQ-014 carry_o  output  1  final carry out; for subtraction, 1 means no borrow.
REQ-015 overflow_o  output  1  two's-complement signed overflow.
REQ-016 zero_o  output  1  high when result_o equals 0.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 ready_o SHALL be 1 only when the state is IDLE and rst_ni is 1.
REQ-019 An acceptance edge is a rising edge with valid_i=1 and ready_o=1; on it the block SHALL:
- latch A;
- latch B, or ~B when sub_i=1;
- set initial carry to carry_i, or to 1 when sub_i=1;
- clear the slice index;
- enter RUN.
REQ-020 In RUN, each edge SHALL add one SLICE-bit slice, LSB slice first, and propagate the carry to the next slice through a register.
REQ-021 After the edge that processes slice N-1, the state SHALL be DONE and valid_o SHALL be 1; valid_o therefore rises exactly N cycles after the acceptance edge.
REQ-022 In DONE:
- result_o, carry_o, overflow_o and zero_o SHALL hold stable while valid_o=1 and ready_i=0;
- on an edge with ready_i=1, the block SHALL return to IDLE and valid_o SHALL drop.
REQ-023 valid_i SHALL be ignored in RUN and DONE; no request is queued and the latched operands are not disturbed.
REQ-024 A new request SHALL be acceptable no earlier than the cycle after the DONE handshake, so the minimum issue interval is N+2 cycles.
REQ-025 overflow_o SHALL be computed from the operand MSBs and the result MSB (A, effective B, result).
REQ-026 zero_o SHALL be evaluated on the final result_o value.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, with wrap-around, except as stated in REQ-031.
REQ-028 For N=1, RUN SHALL last one cycle and valid_o SHALL rise 1 cycle after acceptance.

Reset
REQ-029 On an edge with rst_ni=0 the block SHALL:
- go to IDLE;
- clear valid_o, result_o, carry_o, overflow_o, zero_o, the slice index and the carry register.
This applies in any state, including mid-RUN and in DONE; the in-flight operation SHALL be discarded with no partial result shown.
REQ-030 While rst_ni=0, ready_o SHALL be 0 and valid_i SHALL be ignored; ready_o SHALL be 1 in the first cycle after rst_ni returns high.

Configuration
REQ-031 With macro SUMADOR_SATURACION_EN defined, a signed overflow SHALL clamp result_o:
- to 2^(WIDTH-1)-1 when A is positive;
- to -2^(WIDTH-1) when A is negative.
In this case overflow_o SHALL still be 1 and carry_o SHALL be unchanged; zero_o SHALL reflect the clamped value.
REQ-032 Without SUMADOR_SATURACION_EN, result_o SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be synthesised.

Verification (WIDTH=32, SLICE=8, N=4 unless stated)
REQ-033 Add with carry chain: A=0xFFFFFFFF, B=0x00000001, carry_i=0, sub_i=0 -> valid_o rises 4 cycles after acceptance; result_o=0x00000000, carry_o=1, overflow_o=0, zero_o=1.
REQ-034 Signed overflow: A=0x7FFFFFFF, B=0x00000001 -> without macro result_o=0x80000000 and overflow_o=1; with SUMADOR_SATURACION_EN result_o=0x7FFFFFFF and overflow_o=1.
REQ-035 Subtraction: A=5, B=7, sub_i=1, carry_i=1 (ignored) -> result_o=0xFFFFFFFE, carry_o=0, overflow_o=0, zero_o=0.
REQ-036 Backpressure: hold ready_i=0 for 3 cycles in DONE and pulse valid_i with new operands -> outputs stay unchanged, ready_o=0, and the new request is never accepted; ready_i=1 -> IDLE next cycle and ready_o=1.
REQ-037 Reset mid-operation: assert rst_ni=0 for one edge while RUN is on slice 2 -> all outputs 0 and valid_o never rises for that request; ready_o=1 one cycle after release; a fresh request 3+4 -> result_o=7.
REQ-038 N=1 build (WIDTH=8, SLICE=8): A=0x80, B=0x80 -> after 1 cycle result_o=0x00, carry_o=1, overflow_o=1, zero_o=1 without macro; result_o=0x80 and zero_o=0 with SUMADOR_SATURACION_EN.
